mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator_pkg.sv | 16 +
 rtl/mac_accumulator_if.sv | 43 ++++
 rtl/mac_accumulator_datapath.sv | 87 ++++++++
 rtl/mac_accumulator.sv | 85 ++++++++
 tb/tb_mac_accumulator.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mac_accumulator_pkg.sv
// Shared types and default widths for the MAC accumulator slice.
// Optional saturation is selected with the MAC_SATURATE_EN macro.
package mac_pkg;

  localparam int DefDataWidth  = 16;
  localparam int DefAccWidth   = 40;
  localparam int DefCountWidth = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } mac_state_e;

endpackage

// File: rtl/mac_accumulator_if.sv
// FIFO, job and result handshake bundle of the MAC accumulator.
// The Overflow flag exists only when MAC_SATURATE_EN is defined.
interface mac_accumulator_if
  import mac_pkg::*;
#(
  parameter int DataWidth  = DefDataWidth,
  parameter int AccWidth   = DefAccWidth,
  parameter int CountWidth = DefCountWidth
) ();

  logic                  Start;
  logic [CountWidth-1:0] Length;
  logic                  W_Empty;
  logic                  X_Empty;
  logic [DataWidth-1:0]  W_Data;
  logic [DataWidth-1:0]  X_Data;
  logic                  W_Pop;
  logic                  X_Pop;
  logic [AccWidth-1:0]   Result;
  logic                  ResultValid;
  logic                  ResultReady;
  logic                  Busy;
`ifdef MAC_SATURATE_EN
  logic                  Overflow;
`endif

  modport master (
    output Start, Length, W_Empty, X_Empty, W_Data, X_Data, ResultReady,
    input  W_Pop, X_Pop, Result, ResultValid, Busy
`ifdef MAC_SATURATE_EN
    , input Overflow
`endif
  );

  modport slave (
    input  Start, Length, W_Empty, X_Empty, W_Data, X_Data, ResultReady,
    output W_Pop, X_Pop, Result, ResultValid, Busy
`ifdef MAC_SATURATE_EN
    , output Overflow
`endif
  );

endinterface

// File: rtl/mac_accumulator_datapath.sv
// Multiply / product register / accumulate path of the MAC accumulator.
// With MAC_SATURATE_EN the accumulator clamps and keeps a sticky overflow flag.
module mac_datapath
  import mac_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int AccWidth  = DefAccWidth
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic                        capture_i,
  input  logic signed [DataWidth-1:0] wData_i,
  input  logic signed [DataWidth-1:0] xData_i,
  output logic signed [AccWidth-1:0]  acc_o,
  output logic                        prodValid_o
`ifdef MAC_SATURATE_EN
  , output logic                      overflow_o
`endif
);

  localparam int ProdWidth = 2 * DataWidth;

  logic signed [ProdWidth-1:0] prod_q;
  logic                        prodValid_q;
  logic signed [AccWidth-1:0]  acc_q;
  logic signed [AccWidth-1:0]  acc_d;
  logic signed [AccWidth-1:0]  prodExt;
  logic signed [AccWidth-1:0]  sum;

  assign prodExt = AccWidth'(prod_q);
  assign sum     = acc_q + prodExt;

`ifdef MAC_SATURATE_EN
  logic overflow_q;
  logic overflowNow;

  // Signed overflow: both addends share a sign that the sum does not.
  always_comb begin
    overflowNow = (acc_q[AccWidth-1] == prodExt[AccWidth-1]) &&
                  (sum[AccWidth-1] != acc_q[AccWidth-1]);
    acc_d       = sum;
    if (overflowNow) begin
      acc_d = acc_q[AccWidth-1] ? {1'b1, {(AccWidth-1){1'b0}}}
                                : {1'b0, {(AccWidth-1){1'b1}}};
    end
  end
`else
  always_comb begin
    acc_d = sum;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q      <= '0;
      prodValid_q <= 1'b0;
      acc_q       <= '0;
`ifdef MAC_SATURATE_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      prodValid_q <= capture_i;
      if (capture_i) begin
        prod_q <= ProdWidth'(wData_i) * ProdWidth'(xData_i);
      end
      if (clear_i) begin
        acc_q      <= '0;
`ifdef MAC_SATURATE_EN
        overflow_q <= 1'b0;
`endif
      end else if (prodValid_q) begin
        acc_q      <= acc_d;
`ifdef MAC_SATURATE_EN
        overflow_q <= overflow_q | overflowNow;
`endif
      end
    end
  end

  assign acc_o       = acc_q;
  assign prodValid_o = prodValid_q;
`ifdef MAC_SATURATE_EN
  assign overflow_o  = overflow_q;
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product MAC: pops paired W/X FIFO words and returns a signed sum.
// Define MAC_SATURATE_EN for saturating accumulation with an Overflow flag.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int DataWidth  = DefDataWidth,
  parameter int AccWidth   = DefAccWidth,
  parameter int CountWidth = DefCountWidth
) (
  input  logic           clk,
  input  logic           rst,
  mac_accumulator_if.slave bus
);

  mac_state_e             state_q;
  logic [CountWidth-1:0]  remaining_q;
  logic                   popEn;
  logic                   clearAcc;
  logic                   prodValid;
  logic signed [AccWidth-1:0] acc;

  // Both FIFOs advance together, and never while reset is held.
  assign popEn = (state_q == RUN) && (remaining_q != '0) &&
                 !bus.W_Empty && !bus.X_Empty && !rst;
  assign clearAcc = (state_q == IDLE) && bus.Start && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.Start) begin
            remaining_q <= bus.Length;
            state_q     <= (bus.Length == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (popEn) begin
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == CountWidth'(1)) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (prodValid) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.ResultReady) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mac_datapath #(
    .DataWidth(DataWidth),
    .AccWidth (AccWidth)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clearAcc),
    .capture_i  (popEn),
    .wData_i    (bus.W_Data),
    .xData_i    (bus.X_Data),
    .acc_o      (acc),
    .prodValid_o(prodValid)
`ifdef MAC_SATURATE_EN
    , .overflow_o(bus.Overflow)
`endif
  );

  assign bus.W_Pop       = popEn;
  assign bus.X_Pop       = popEn;
  assign bus.ResultValid = (state_q == DONE) && !rst;
  assign bus.Busy        = (state_q != IDLE) && !rst;
  assign bus.Result      = rst ? '0 : acc;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: table-driven jobs with a result
// scoreboard, plus abort-on-reset and 32-bit overflow sequences (MAC_SATURATE_EN aware).
module tb_mac_accumulator;

  localparam int DW  = 16;
  localparam int AW  = 40;
  localparam int CW  = 8;
  localparam int AW2 = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_accumulator_if #(.DataWidth(DW), .AccWidth(AW),  .CountWidth(CW)) bus ();
  mac_accumulator_if #(.DataWidth(DW), .AccWidth(AW2), .CountWidth(CW)) bus2 ();

  mac_accumulator #(.DataWidth(DW), .AccWidth(AW), .CountWidth(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  mac_accumulator #(.DataWidth(DW), .AccWidth(AW2), .CountWidth(CW)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int nTotal = 0;
  int nBad   = 0;

  // FIFO model: shared read pointer because both FIFOs pop together
  logic [DW-1:0] wMem [16];
  logic [DW-1:0] xMem [16];
  int rdPtr      = 0;
  int wrCnt      = 0;
  int jobBase    = 0;
  int stallAt    = -1;
  int stallLen   = 0;
  int stallBase  = 0;
  int stallTotal = 0;
  int cyc        = 0;
  logic xStall;

  assign xStall      = ((rdPtr - jobBase) == stallAt) && ((stallTotal - stallBase) < stallLen);
  assign bus.W_Empty = (rdPtr == wrCnt);
  assign bus.X_Empty = (rdPtr == wrCnt) || xStall;
  assign bus.W_Data  = wMem[rdPtr[3:0]];
  assign bus.X_Data  = xMem[rdPtr[3:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.W_Pop) rdPtr <= rdPtr + 1;
    if (xStall) stallTotal <= stallTotal + 1;
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nTotal++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pop strobes must match and never fire into an empty FIFO
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("popRule",
                  ((bus.W_Pop === bus.X_Pop) && !(bus.W_Pop && (bus.W_Empty || bus.X_Empty))) ? 1 : 0,
                  1);
    end
  end

  typedef struct {
    string  tag;
    int     len;
    int     w0, w1, w2, w3;
    int     x0, x1, x2, x3;
    int     stallAt;
    int     stallLen;
    int     hold;
    int     latency;
    longint expected;
  } jobVec_t;

  jobVec_t vecs [5];
  longint  expQ [$];

  task automatic applyStimulus(input jobVec_t v);
    int wl [4];
    int xl [4];
    int n;
    int startCyc;
    longint exp;
    wl = '{v.w0, v.w1, v.w2, v.w3};
    xl = '{v.x0, v.x1, v.x2, v.x3};
    jobBase   = rdPtr;
    stallAt   = v.stallAt;
    stallLen  = v.stallLen;
    stallBase = stallTotal;
    for (int i = 0; i < v.len; i++) begin
      wMem[wrCnt % 16] = DW'(wl[i]);
      xMem[wrCnt % 16] = DW'(xl[i]);
      wrCnt++;
    end
    expQ.push_back(v.expected);
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.Length = CW'(v.len);
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    startCyc  = cyc;
    n = 0;
    while (!bus.ResultValid && n < 200) begin
      @(negedge clk);
      n++;
    end
    exp = expQ.pop_front();
    if (!bus.ResultValid) begin
      checkOutput({v.tag, " timeout"}, 0, 1);
    end else begin
      checkOutput({v.tag, " latency"}, cyc - startCyc, v.latency);
      checkOutput({v.tag, " pops"}, rdPtr - jobBase, v.len);
      checkOutput({v.tag, " result"}, $signed(bus.Result), exp);
      // A Start during DONE must be ignored while the result is held
      for (int h = 0; h < v.hold; h++) begin
        bus.Start  = 1'b1;
        bus.Length = '0;
        @(negedge clk);
        checkOutput({v.tag, " holdValid"}, bus.ResultValid, 1);
        checkOutput({v.tag, " holdResult"}, $signed(bus.Result), exp);
      end
      bus.Start       = 1'b0;
      bus.ResultReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.ResultReady = 1'b0;
      checkOutput({v.tag, " validDrop"}, bus.ResultValid, 0);
      checkOutput({v.tag, " idleBusy"}, bus.Busy, 0);
    end
    stallAt = -1;
  endtask

  initial begin
    int n;
    longint exp2;
    bus.Start = 1'b0;  bus.Length = '0;  bus.ResultReady = 1'b0;
    bus2.Start = 1'b0; bus2.Length = '0; bus2.ResultReady = 1'b0;
    bus2.W_Empty = 1'b0; bus2.X_Empty = 1'b0;
    bus2.W_Data = 16'h8000; bus2.X_Data = 16'h8000;

    vecs[0] = '{"basic",  4, 1, 2, 3, 4, 5, 6, 7, 8, -1, 0, 0, 5, 70};
    vecs[1] = '{"stall",  4, 1, 2, 3, 4, 5, 6, 7, 8,  2, 3, 0, 8, 70};
    vecs[2] = '{"signed", 2, -3, 32767, 0, 0, 5, -2, 0, 0, -1, 0, 3, 3, -65549};
    vecs[3] = '{"zeroLen", 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 5, 0, 0};
    vecs[4] = '{"extremes", 3, -32768, -32768, 100, 0, -32768, 1, -1, 0, -1, 0, 0, 4, 1073708956};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstPop", bus.W_Pop, 0);
    checkOutput("rstValid", bus.ResultValid, 0);
    checkOutput("rstBusy", bus.Busy, 0);
    checkOutput("rstResult", $signed(bus.Result), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
    end

    // Abort after two of four pops, then a fresh job must start from zero
    jobBase = rdPtr;
    for (int i = 0; i < 4; i++) begin
      wMem[wrCnt % 16] = DW'(i + 1);
      xMem[wrCnt % 16] = DW'(i + 5);
      wrCnt++;
    end
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.Length = CW'(4);
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    n = 0;
    while ((rdPtr - jobBase) < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abortReach", rdPtr - jobBase, 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abortPop", bus.W_Pop, 0);
    checkOutput("abortValid", bus.ResultValid, 0);
    checkOutput("abortBusy", bus.Busy, 0);
    checkOutput("abortPopsTaken", rdPtr - jobBase, 2);
    rst = 1'b0;
    wrCnt = rdPtr;
    vecs[0].tag = "afterAbort";
    applyStimulus(vecs[0]);

    // Three products of 2^30 overflow a 32-bit signed accumulator
`ifdef MAC_SATURATE_EN
    exp2 = 64'sd2147483647;
`else
    exp2 = -64'sd1073741824;
`endif
    @(negedge clk);
    bus2.Start  = 1'b1;
    bus2.Length = CW'(3);
    @(posedge clk);
    @(negedge clk);
    bus2.Start = 1'b0;
    n = 0;
    while (!bus2.ResultValid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ovfValid", bus2.ResultValid, 1);
    checkOutput("ovfResult", $signed(bus2.Result), exp2);
`ifdef MAC_SATURATE_EN
    checkOutput("ovfFlag", bus2.Overflow, 1);
`endif
    bus2.ResultReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus2.ResultReady = 1'b0;
    checkOutput("ovfValidDrop", bus2.ResultValid, 0);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
